// File: rtl/mbist_pkg.sv
// Shared definitions for the march-test generator: algorithm and state encodings,
// plus the per-algorithm element tables that drive the sequencer.
package mbist_pkg;

  typedef enum logic [1:0] {
    ALGO_CKB      = 2'b00,
    ALGO_MARCH_X  = 2'b01,
    ALGO_MARCH_CM = 2'b10,
    ALGO_RSVD     = 2'b11
  } algo_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } state_t;

  // pol selects "0"/"1" for march data, or C/~C when the algorithm is checkerboard
  typedef struct packed {
    logic down;
    logic two_ops;
    logic we0;
    logic pol0;
    logic we1;
    logic pol1;
  } elem_t;

  localparam int MAX_ELEMS = 6;

  localparam elem_t EL_W0   = '{down: 1'b0, two_ops: 1'b0, we0: 1'b1, pol0: 1'b0, we1: 1'b0, pol1: 1'b0};
  localparam elem_t EL_W1   = '{down: 1'b0, two_ops: 1'b0, we0: 1'b1, pol0: 1'b1, we1: 1'b0, pol1: 1'b0};
  localparam elem_t EL_R0   = '{down: 1'b0, two_ops: 1'b0, we0: 1'b0, pol0: 1'b0, we1: 1'b0, pol1: 1'b0};
  localparam elem_t EL_R1   = '{down: 1'b0, two_ops: 1'b0, we0: 1'b0, pol0: 1'b1, we1: 1'b0, pol1: 1'b0};
  localparam elem_t EL_R0W1 = '{down: 1'b0, two_ops: 1'b1, we0: 1'b0, pol0: 1'b0, we1: 1'b1, pol1: 1'b1};
  localparam elem_t EL_R1W0 = '{down: 1'b0, two_ops: 1'b1, we0: 1'b0, pol0: 1'b1, we1: 1'b1, pol1: 1'b0};

  function automatic elem_t elem_tbl(algo_t algo, logic [2:0] idx);
    elem_t e;
    e = EL_R0;
    case (algo)
      ALGO_CKB: begin
        case (idx)
          3'd0:    e = EL_W0;
          3'd1:    e = EL_R0;
          3'd2:    e = EL_W1;
          default: e = EL_R1;
        endcase
      end
      ALGO_MARCH_X: begin
        case (idx)
          3'd0:    e = EL_W0;
          3'd1:    e = EL_R0W1;
          3'd2:    begin e = EL_R1W0; e.down = 1'b1; end
          default: e = EL_R0;
        endcase
      end
      default: begin
        case (idx)
          3'd0:    e = EL_W0;
          3'd1:    e = EL_R0W1;
          3'd2:    e = EL_R1W0;
          3'd3:    begin e = EL_R0W1; e.down = 1'b1; end
          3'd4:    begin e = EL_R1W0; e.down = 1'b1; end
          default: e = EL_R0;
        endcase
      end
    endcase
    return e;
  endfunction

  function automatic logic [2:0] n_elems(algo_t algo);
    case (algo)
      ALGO_CKB:     return 3'd4;
      ALGO_MARCH_X: return 3'd4;
      default:      return 3'(MAX_ELEMS);
    endcase
  endfunction

endpackage

// File: rtl/mbist_march_gen_if.sv
// Control, status and memory-port bundle of the march generator.
// master = generator side, slave = memory / test-controller side.
interface mbist_march_gen_if #(
  parameter int ADDR = 8,
  parameter int DATA = 8
);
  logic            start;
  logic [1:0]      algo;
  logic [DATA-1:0] rdata;
  logic            mem_en;
  logic            mem_we;
  logic [ADDR-1:0] mem_addr;
  logic [DATA-1:0] mem_wdata;
  logic            busy;
  logic            done;
  logic            fail;
  logic [ADDR-1:0] fail_addr;

  modport master (
    input  start, algo, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy, done, fail, fail_addr
  );

  modport slave (
    output start, algo, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy, done, fail, fail_addr
  );
endinterface

// File: rtl/mbist_data_gen.sv
// Combinational data word for the current op: solid 0/1 or checkerboard C/~C.
// Checkerboard phase is row[0] ^ col[0], flipped on odd bit positions.
module mbist_data_gen #(
  parameter int ADDR = 8,
  parameter int DATA = 8
) (
  input  logic [ADDR-1:0] addr,
  input  logic            pol,
  input  logic            ckb,
  output logic [DATA-1:0] data
);
  // row LSB sits at ADDR/2, col LSB at 0
  localparam logic [ADDR-1:0] LSB_MASK = (ADDR'(1) << (ADDR / 2)) | ADDR'(1);

  logic phase;

  always_comb begin
    phase = ^(addr & LSB_MASK);
    data  = '0;
    for (int i = 0; i < DATA; i++) begin
      data[i] = pol ^ (ckb & (phase ^ i[0]));
    end
  end
endmodule

// File: rtl/mbist_march_gen.sv
// March / checkerboard MBIST sequencer: one registered memory op per RUN cycle,
// one-stage read compare, sticky first-fail capture, done pulse after the last compare.
module mbist_march_gen
  import mbist_pkg::*;
#(
  parameter int ADDR = 8,
  parameter int DATA = 8
) (
  input  logic               clk,
  input  logic               rst,
  mbist_march_gen_if.master  bus
);
  state_t          state;
  algo_t           algo_q;
  algo_t           algo_sel;
  logic [2:0]      elem;
  logic            op;
  logic [ADDR-1:0] cnt;

  elem_t           e;
  logic            cur_we;
  logic            cur_pol;
  logic            cur_ckb;
  logic [ADDR-1:0] cur_addr;
  logic [DATA-1:0] cur_data;
  logic            seq_end;
  logic            issue;

  logic            mem_en_q;
  logic            mem_we_q;
  logic [ADDR-1:0] mem_addr_q;
  logic [DATA-1:0] mem_wdata_q;
  logic            busy_q;
  logic            done_q;
  logic            fail_q;
  logic [ADDR-1:0] fail_addr_q;

  logic            cmp_vld;
  logic [DATA-1:0] cmp_exp;
  logic [ADDR-1:0] cmp_addr;

  // In IDLE the incoming algo selects the first op so it can issue on the start edge
  always_comb begin
    algo_sel = (state == ST_IDLE) ? algo_t'(bus.algo) : algo_q;
    e        = elem_tbl(algo_sel, elem);
    cur_we   = op ? e.we1  : e.we0;
    cur_pol  = op ? e.pol1 : e.pol0;
    cur_ckb  = (algo_sel == ALGO_CKB);
    cur_addr = e.down ? ~cnt : cnt;
    seq_end  = (elem == n_elems(algo_q));
    issue    = ((state == ST_IDLE) && bus.start) || ((state == ST_RUN) && !seq_end);
  end

  mbist_data_gen #(.ADDR(ADDR), .DATA(DATA)) u_data_gen (
    .addr (cur_addr),
    .pol  (cur_pol),
    .ckb  (cur_ckb),
    .data (cur_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      algo_q      <= ALGO_CKB;
      elem        <= '0;
      op          <= 1'b0;
      cnt         <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      cmp_vld     <= 1'b0;
      cmp_exp     <= '0;
      cmp_addr    <= '0;
    end else begin
      done_q   <= 1'b0;
      cmp_vld  <= mem_en_q & ~mem_we_q;
      cmp_exp  <= mem_wdata_q;
      cmp_addr <= mem_addr_q;

      if (cmp_vld && (bus.rdata != cmp_exp) && !fail_q) begin
        fail_q      <= 1'b1;
        fail_addr_q <= cmp_addr;
      end

      if (issue) begin
        mem_en_q    <= 1'b1;
        mem_we_q    <= cur_we;
        mem_addr_q  <= cur_addr;
        mem_wdata_q <= cur_data;
        // all ops of an element finish at one address; element advances on address wrap
        if (e.two_ops && !op) begin
          op <= 1'b1;
        end else begin
          op  <= 1'b0;
          cnt <= cnt + 1'b1;
          if (&cnt) elem <= elem + 3'd1;
        end
      end else begin
        mem_en_q    <= 1'b0;
        mem_we_q    <= 1'b0;
        mem_addr_q  <= '0;
        mem_wdata_q <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state       <= ST_RUN;
            algo_q      <= algo_t'(bus.algo);
            busy_q      <= 1'b1;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
          end
        end
        ST_RUN: begin
          if (seq_end) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          elem   <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.fail_addr = fail_addr_q;
endmodule

// File: tb/tb_mbist_march_gen.sv
// Scoreboard bench: expected op stream built from textual march descriptions,
// memory model with an optional stuck-at fault, monitor pops and compares each op.
module tb_mbist_march_gen;
  localparam int ADDR = 4;
  localparam int DATA = 8;
  localparam int N    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mbist_march_gen_if #(.ADDR(ADDR), .DATA(DATA)) bus ();
  mbist_march_gen #(.ADDR(ADDR), .DATA(DATA)) dut (.clk(clk), .rst(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  logic [12:0] exp_q[$];
  int op_cnt;
  int done_cnt;
  int w5_n;
  logic [7:0] w5_first, w5_last;

  logic [7:0] mem[N];
  logic [3:0] f_addr;
  logic [7:0] f_mask, f_val;
  logic       rd_pend = 1'b0;
  logic [7:0] rd_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // memory: write/read sampled mid-cycle, read data presented during the following cycle
  always @(negedge clk) begin
    if (rd_pend) bus.rdata = rd_val;
    rd_pend = 1'b0;
    if (!rst && bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] = bus.mem_wdata;
      end else begin
        rd_val = mem[bus.mem_addr];
        if (bus.mem_addr == f_addr) rd_val = (rd_val & ~f_mask) | (f_val & f_mask);
        rd_pend = 1'b1;
      end
    end
  end

  // monitor
  always @(negedge clk) begin
    logic [12:0] e;
    if (!rst) begin
      if (bus.mem_en) begin
        op_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_op_queue_depth", 32'(exp_q.size()), 1);
        end else begin
          e = exp_q.pop_front();
          check("op_we_addr_data", 32'({bus.mem_we, bus.mem_addr, bus.mem_wdata}), 32'(e));
        end
        if (bus.mem_we && bus.mem_addr == 4'd5) begin
          if (w5_n == 0) w5_first = bus.mem_wdata;
          w5_last = bus.mem_wdata;
          w5_n++;
        end
      end else begin
        check("idle_wdata", 32'(bus.mem_wdata), 0);
      end
      if (bus.done) begin
        done_cnt++;
        check("busy_at_done", 32'(bus.busy), 0);
      end
    end
  end

  // reference: element strings "<U|D>:<op><val>..." with val 0, 1, C or N (=~C)
  function automatic void build_model(input int a, output logic exp_fail, output logic [3:0] exp_faddr);
    string el[$];
    string s;
    int nops, adr, row, col;
    byte dirc, opc, valc;
    logic we;
    logic [7:0] d;
    exp_fail = 1'b0;
    exp_faddr = '0;
    if (a == 0) begin
      el.push_back("U:wC"); el.push_back("U:rC"); el.push_back("U:wN"); el.push_back("U:rN");
    end else if (a == 1) begin
      el.push_back("U:w0"); el.push_back("U:r0w1"); el.push_back("D:r1w0"); el.push_back("U:r0");
    end else begin
      el.push_back("U:w0"); el.push_back("U:r0w1"); el.push_back("U:r1w0");
      el.push_back("D:r0w1"); el.push_back("D:r1w0"); el.push_back("U:r0");
    end
    foreach (el[j]) begin
      s = el[j];
      dirc = s[0];
      nops = (s.len() - 2) / 2;
      for (int k = 0; k < N; k++) begin
        adr = (dirc == "D") ? (N - 1 - k) : k;
        row = adr / 4;
        col = adr % 4;
        for (int o = 0; o < nops; o++) begin
          opc  = s[2 + 2 * o];
          valc = s[3 + 2 * o];
          we   = (opc == "w");
          if (valc == "0") d = 8'h00;
          else if (valc == "1") d = 8'hFF;
          else begin
            for (int i = 0; i < DATA; i++) d[i] = 1'((row ^ col ^ i) & 1);
            if (valc == "N") d = ~d;
          end
          exp_q.push_back({we, 4'(adr), d});
          if (!we && 4'(adr) == f_addr && !exp_fail && (((d & ~f_mask) | (f_val & f_mask)) != d)) begin
            exp_fail  = 1'b1;
            exp_faddr = 4'(adr);
          end
        end
      end
    end
  endfunction

  task automatic run_test(input string tag, input int a, input bit hold,
                          input logic [3:0] fa, input logic [7:0] fm, input logic [7:0] fv);
    logic ef;
    logic [3:0] efa;
    int n_exp;
    bit seen;
    logic got_fail;
    logic [3:0] got_fa;
    f_addr = fa; f_mask = fm; f_val = fv;
    exp_q.delete();
    build_model(a, ef, efa);
    n_exp = exp_q.size();
    op_cnt = 0; done_cnt = 0; w5_n = 0;
    got_fail = 1'b0; got_fa = '0; seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.algo  = 2'(a);
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(bus.busy), 1);
    check({tag, "_mem_en_after_start"}, 32'(bus.mem_en), 1);
    for (int c = 0; c < 2000 && !seen; c++) begin
      @(negedge clk);
      if (hold) bus.algo = 2'($urandom_range(0, 3));
      if (bus.done) begin
        seen = 1'b1;
        got_fail = bus.fail;
        got_fa = bus.fail_addr;
      end
    end
    bus.start = 1'b0;
    check({tag, "_done_seen"}, 32'(seen), 1);
    repeat (3) @(negedge clk);
    check({tag, "_op_count"}, 32'(op_cnt), 32'(n_exp));
    check({tag, "_queue_left"}, 32'(exp_q.size()), 0);
    check({tag, "_fail"}, 32'(got_fail), 32'(ef));
    check({tag, "_fail_addr"}, 32'(got_fa), 32'(efa));
    check({tag, "_done_count"}, 32'(done_cnt), 1);
    check({tag, "_busy_idle"}, 32'(bus.busy), 0);
  endtask

  initial begin
    logic ef;
    logic [3:0] efa;
    int a;
    int b;
    logic [3:0] fa;
    logic [7:0] fm, fv;
    bus.start = 1'b0;
    bus.algo  = 2'b00;
    bus.rdata = '0;
    f_addr = '0; f_mask = '0; f_val = '0;
    op_cnt = 0; done_cnt = 0; w5_n = 0;
    w5_first = '0; w5_last = '0;

    @(negedge clk);
    check("reset_outputs", 32'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                                bus.busy, bus.done, bus.fail, bus.fail_addr}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_test("marchcm_ideal", 2, 1'b0, 4'd0, 8'h00, 8'h00);
    check("marchcm_ops_160", 32'(op_cnt), 160);
    run_test("marchx_sa1_a5b3", 1, 1'b0, 4'd5, 8'h08, 8'h08);
    check("marchx_ops_96", 32'(op_cnt), 96);
    run_test("ckb_ideal", 0, 1'b0, 4'd0, 8'h00, 8'h00);
    check("ckb_ops_64", 32'(op_cnt), 64);
    check("ckb_a5_writes", 32'(w5_n), 2);
    check("ckb_a5_wC", 32'(w5_first), 32'h00AA);
    check("ckb_a5_wnotC", 32'(w5_last), 32'h0055);
    run_test("algo3_marchcm", 3, 1'b0, 4'd9, 8'h01, 8'h00);

    // abort a March C- run after a fail has been latched
    f_addr = 4'd0; f_mask = 8'h01; f_val = 8'h01;
    exp_q.delete();
    build_model(2, ef, efa);
    done_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.algo = 2'd2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_abort_fail", 32'(bus.fail), 1);
    rst = 1'b1;
    #1;
    check("abort_outputs", 32'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata,
                                bus.busy, bus.done, bus.fail, bus.fail_addr}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 0);
    run_test("rerun_after_abort", 2, 1'b0, 4'd0, 8'h00, 8'h00);

    run_test("hold_start_marchx", 1, 1'b1, 4'd12, 8'h80, 8'h00);

    for (int r = 0; r < 6; r++) begin
      a  = $urandom_range(0, 3);
      fa = 4'($urandom_range(0, 15));
      b  = $urandom_range(0, 7);
      fm = ($urandom_range(0, 1) == 1) ? 8'(1 << b) : 8'h00;
      fv = ($urandom_range(0, 1) == 1) ? fm : 8'h00;
      run_test($sformatf("rand%0d", r), a, 1'b0, fa, fm, fv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
